// File: rtl/ex_alu_stage_if.sv
// ex_alu_stage_if: operand/command side and result-slot side of the EX ALU stage
//   master: issues ops (in_valid, alu_ctl, jr_ctl, src_a, src_b, shamt, dest_in, flush) and consumes results (out_ready)
//   slave: the stage itself (in_ready, out_valid, result, zero, overflow, jr_taken, illegal, dest_out)
interface ex_alu_stage_if #(
  parameter int WIDTH = 32,
  parameter int REG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctl;
  logic             jr_ctl;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [4:0]       shamt;
  logic [REG_W-1:0] dest_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             jr_taken;
  logic             illegal;
  logic [REG_W-1:0] dest_out;
  modport master (
    output in_valid, alu_ctl, jr_ctl, src_a, src_b, shamt, dest_in, flush, out_ready,
    input  in_ready, out_valid, result, zero, overflow, jr_taken, illegal, dest_out
  );
  modport slave (
    input  in_valid, alu_ctl, jr_ctl, src_a, src_b, shamt, dest_in, flush, out_ready,
    output in_ready, out_valid, result, zero, overflow, jr_taken, illegal, dest_out
  );
endinterface

// File: rtl/ex_alu_stage.sv
// ex_alu_stage: EX-stage ALU with single-cycle arith/logic and iterative shifter feeding a registered result slot
//   clk, reset_n (async active-low); bus: ex_alu_stage_if.slave carrying the issue handshake,
//   operands and the result slot (out_valid/out_ready, result, zero, overflow, jr_taken, illegal, dest_out)
module ex_alu_stage #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1,
  parameter int REG_W      = 5
) (
  input logic          clk,
  input logic          reset_n,
  ex_alu_stage_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam logic [4:0] STEP = 5'(SHIFT_STEP);
  state_t           state, state_nx;
  logic [WIDTH-1:0] sh_val, sh_next, sra_val, sum, diff, c_res;
  logic [4:0]       sh_rem, sh_amt;
  logic [1:0]       sh_op;
  logic [REG_W-1:0] sh_dest;
  logic             accept, is_shift, go_shift, load_imm, load_sh, sh_done, c_ovf, c_ill;
  assign bus.in_ready = state == IDLE && (!bus.out_valid || bus.out_ready) && !bus.flush;
  assign accept   = bus.in_valid && bus.in_ready;
  assign is_shift = !bus.jr_ctl && bus.alu_ctl inside {4'd4, 4'd5, 4'd6};
  // a zero-distance shift is just a copy of src_b and completes like any single-cycle op
  assign go_shift = accept && is_shift && bus.shamt != 5'd0;
  assign load_imm = accept && !go_shift;
  assign sh_amt   = sh_rem < STEP ? sh_rem : STEP;
  assign sh_done  = sh_rem <= STEP;
  assign load_sh  = state == SHIFT && sh_done && !bus.flush;
  assign sum      = bus.src_a + bus.src_b;
  assign diff     = bus.src_a - bus.src_b;
  // kept as its own assignment so the arithmetic shift is evaluated in signed context
  assign sra_val  = $signed(sh_val) >>> sh_amt;
  assign sh_next  = sh_op == 2'd0 ? sh_val << sh_amt : sh_op == 2'd1 ? sh_val >> sh_amt : sra_val;
  always_comb begin
    c_res = '0;
    c_ovf = 1'b0;
    c_ill = 1'b0;
    if (bus.jr_ctl) c_res = bus.src_a;
    else
      case (bus.alu_ctl)
        4'd0: begin
          c_res = sum;
          c_ovf = bus.src_a[WIDTH-1] == bus.src_b[WIDTH-1] && sum[WIDTH-1] != bus.src_a[WIDTH-1];
        end
        4'd1: begin
          c_res = diff;
          c_ovf = bus.src_a[WIDTH-1] != bus.src_b[WIDTH-1] && diff[WIDTH-1] != bus.src_a[WIDTH-1];
        end
        4'd2: c_res = bus.src_a & bus.src_b;
        4'd3: c_res = bus.src_a | bus.src_b;
        4'd4, 4'd5, 4'd6: c_res = bus.src_b;
        4'd7: c_res = ~(bus.src_a | bus.src_b);
        4'd8: c_res = {{(WIDTH-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
        default: c_ill = 1'b1;
      endcase
  end
  always_comb begin
    state_nx = state;
    if (bus.flush) state_nx = IDLE;
    else if (go_shift) state_nx = SHIFT;
    else if (load_sh) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.zero      <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.jr_taken  <= 1'b0;
      bus.illegal   <= 1'b0;
      bus.dest_out  <= '0;
      sh_val        <= '0;
      sh_rem        <= '0;
      sh_op         <= '0;
      sh_dest       <= '0;
    end else begin
      bus.out_valid <= !bus.flush && (load_imm || load_sh || (bus.out_valid && !bus.out_ready));
      if (load_imm) begin
        bus.result   <= c_res;
        bus.zero     <= c_res == '0;
        bus.overflow <= c_ovf;
        bus.jr_taken <= bus.jr_ctl;
        bus.illegal  <= c_ill;
        bus.dest_out <= bus.dest_in;
      end else if (load_sh) begin
        bus.result   <= sh_next;
        bus.zero     <= sh_next == '0;
        bus.overflow <= 1'b0;
        bus.jr_taken <= 1'b0;
        bus.illegal  <= 1'b0;
        bus.dest_out <= sh_dest;
      end
      if (bus.flush) sh_rem <= '0;
      else if (go_shift) begin
        sh_val  <= bus.src_b;
        sh_rem  <= bus.shamt;
        sh_op   <= bus.alu_ctl[1:0];
        sh_dest <= bus.dest_in;
      end else if (state == SHIFT) begin
        sh_val <= sh_next;
        sh_rem <= sh_rem - sh_amt;
      end
    end
endmodule

// File: tb/tb_ex_alu_stage.sv
// tb_ex_alu_stage: directed-vector bench for ex_alu_stage (SHIFT_STEP=1 main instance, SHIFT_STEP=4 latency instance)
module tb_ex_alu_stage;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  int lat, busy;
  always #5 clk = ~clk;
  ex_alu_stage_if #(.WIDTH(32), .REG_W(5)) bus ();
  ex_alu_stage_if #(.WIDTH(32), .REG_W(5)) bus4 ();
  ex_alu_stage #(.WIDTH(32), .SHIFT_STEP(1), .REG_W(5)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  ex_alu_stage #(.WIDTH(32), .SHIFT_STEP(4), .REG_W(5)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4.slave));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic run(input logic [3:0] ctl, input logic jr, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh, input logic [4:0] d, output int l, output int bz);
    bus.alu_ctl = ctl;
    bus.jr_ctl = jr;
    bus.src_a = a;
    bus.src_b = b;
    bus.shamt = sh;
    bus.dest_in = d;
    bus.in_valid = 1'b1;
    #1 check("accept_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.jr_ctl = 1'b0;
    l = 0;
    bz = 0;
    while (!bus.out_valid && l < 100) begin
      l++;
      if (!bus.in_ready) bz++;
      @(negedge clk);
    end
  endtask
  task automatic slot(input string tag, input logic [31:0] r, input logic z, input logic o);
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_result"}, bus.result, r);
    check({tag, "_zero"}, bus.zero, z);
    check({tag, "_ovf"}, bus.overflow, o);
  endtask
  initial begin
    logic [31:0] b4 [2];
    logic [3:0]  c4 [2];
    logic [4:0]  s4 [2];
    logic [31:0] r4 [2];
    int          l4 [2];
    {bus.in_valid, bus.alu_ctl, bus.jr_ctl, bus.src_a, bus.src_b, bus.shamt, bus.dest_in, bus.flush} = '0;
    {bus4.in_valid, bus4.alu_ctl, bus4.jr_ctl, bus4.src_a, bus4.src_b, bus4.shamt, bus4.dest_in, bus4.flush} = '0;
    bus.out_ready = 1'b1;
    bus4.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_dest", bus.dest_out, 0);
    check("rst_flags", {bus.zero, bus.overflow, bus.jr_taken, bus.illegal}, 0);
    check("rst_ready", bus.in_ready, 1);
    reset_n = 1'b1;
    @(negedge clk);
    run(4'd0, 0, 5, 7, 0, 3, lat, busy);
    check("add_lat", lat, 0);
    slot("add", 12, 0, 0);
    check("add_dest", bus.dest_out, 3);
    @(negedge clk);
    check("add_drained", bus.out_valid, 0);
    run(4'd1, 0, 32'h8000_0000, 1, 0, 4, lat, busy);
    slot("sub_ovf", 32'h7FFF_FFFF, 0, 1);
    run(4'd0, 0, 32'h7FFF_FFFF, 1, 0, 4, lat, busy);
    slot("add_ovf", 32'h8000_0000, 0, 1);
    run(4'd0, 0, 32'hFFFF_FFFF, 1, 0, 4, lat, busy);
    slot("add_wrap", 0, 1, 0);
    run(4'd8, 0, 32'hFFFF_FFFF, 1, 0, 4, lat, busy);
    slot("slt_neg", 1, 0, 0);
    run(4'd8, 0, 1, 32'hFFFF_FFFF, 0, 4, lat, busy);
    slot("slt_pos", 0, 1, 0);
    run(4'd2, 0, 32'hF0F0, 32'hFF00, 0, 4, lat, busy);
    slot("and", 32'hF000, 0, 0);
    run(4'd3, 0, 32'hF0F0, 32'hFF00, 0, 4, lat, busy);
    slot("or", 32'hFFF0, 0, 0);
    run(4'd7, 0, 32'h0F0F_0000, 32'h0000_00FF, 0, 4, lat, busy);
    slot("nor", 32'hF0F0_FF00, 0, 0);
    run(4'd4, 0, 0, 32'h1234, 0, 5, lat, busy);
    check("sll0_lat", lat, 0);
    slot("sll0", 32'h1234, 0, 0);
    run(4'd6, 0, 0, 32'h8000_0000, 31, 6, lat, busy);
    check("sra31_lat", lat, 31);
    check("sra31_busy", busy, 31);
    slot("sra31", 32'hFFFF_FFFF, 0, 0);
    check("sra31_dest", bus.dest_out, 6);
    run(4'd5, 0, 0, 32'h8000_0000, 4, 6, lat, busy);
    check("srl4_lat", lat, 4);
    slot("srl4", 32'h0800_0000, 0, 0);
    run(4'd4, 0, 0, 1, 5, 6, lat, busy);
    slot("sll5", 32'h20, 0, 0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    run(4'd0, 0, 1, 2, 0, 8, lat, busy);
    slot("bp_first", 3, 0, 0);
    @(negedge clk);
    check("bp_hold_valid", bus.out_valid, 1);
    check("bp_hold_result", bus.result, 3);
    check("bp_ready_low", bus.in_ready, 0);
    bus.alu_ctl = 4'd0;
    bus.src_a = 10;
    bus.src_b = 20;
    bus.shamt = 0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("bp_still_held", bus.result, 3);
    bus.out_ready = 1'b1;
    #1 check("bp_release_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    slot("bp_no_bubble", 30, 0, 0);
    bus.alu_ctl = 4'd4;
    bus.src_b = 1;
    bus.shamt = 10;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    bus.flush = 1'b1;
    #1 check("flush_ready_low", bus.in_ready, 0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1 check("flush_valid", bus.out_valid, 0);
    check("flush_ready", bus.in_ready, 1);
    repeat (12) @(negedge clk);
    check("flush_killed", bus.out_valid, 0);
    run(4'd4, 1, 32'h400, 32'hFFFF, 3, 9, lat, busy);
    check("jr_lat", lat, 0);
    slot("jr", 32'h400, 0, 0);
    check("jr_taken", bus.jr_taken, 1);
    check("jr_dest", bus.dest_out, 9);
    run(4'hF, 0, 5, 6, 0, 2, lat, busy);
    slot("illegal", 0, 1, 0);
    check("illegal_flag", bus.illegal, 1);
    check("illegal_jr", bus.jr_taken, 0);
    run(4'd0, 0, 90, 9, 0, 7, lat, busy);
    slot("pre_rst", 99, 0, 0);
    bus.alu_ctl = 4'd4;
    bus.src_b = 32'hFF;
    bus.shamt = 20;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_held", bus.result, 99);
    check("pre_rst_busy", bus.in_ready, 0);
    reset_n = 1'b0;
    #1 check("arst_result", bus.result, 0);
    check("arst_dest", bus.dest_out, 0);
    check("arst_ready", bus.in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    check("arst_discard", bus.out_valid, 0);
    b4[0] = 32'h8000_0000; c4[0] = 4'd6; s4[0] = 31; r4[0] = 32'hFFFF_FFFF; l4[0] = 8;
    b4[1] = 32'hF000_0000; c4[1] = 4'd5; s4[1] = 6;  r4[1] = 32'h03C0_0000; l4[1] = 2;
    for (int i = 0; i < 2; i++) begin
      bus4.alu_ctl = c4[i];
      bus4.src_b = b4[i];
      bus4.shamt = s4[i];
      bus4.in_valid = 1'b1;
      #1 check("step4_ready", bus4.in_ready, 1);
      @(negedge clk);
      bus4.in_valid = 1'b0;
      lat = 0;
      while (!bus4.out_valid && lat < 100) begin
        lat++;
        @(negedge clk);
      end
      check("step4_lat", lat, l4[i]);
      check("step4_result", bus4.result, r4[i]);
      @(negedge clk);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
